// File: rtl/ks_cipher_pkg.sv
// ----------------------------------------------------------------------------
// ks_cipher_pkg
// Shared definitions for the keystream XOR cipher.
//   ks_state_t     : keystream sequencer states (IDLE, RELOAD, SKIP, RUN)
//   DEF_*          : default parameter values used by the top level
//   ks_en_for()    : LFSR enable as a function of sequencer state
// ----------------------------------------------------------------------------
package ks_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        SKIP   = 2'd2,
        RUN    = 2'd3
    } ks_state_t;

    localparam int unsigned DEF_BLOCK_SIZE = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_WARMUP     = 16;
    localparam int unsigned DEF_CNT_W      = 32;

    // The LFSR only advances while we are walking or harvesting keystream;
    // every other state holds its enable low, which reloads the seed.
    function automatic logic ks_en_for(input ks_state_t s);
        return (s == SKIP) || (s == RUN);
    endfunction

endpackage

// File: rtl/ks_fifo.sv
// ----------------------------------------------------------------------------
// ks_fifo
// Synchronous FIFO holding prefetched keystream words.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous flush (wins over push/pop)
//   push, din  : write a word; accepted when not full or when popping
//   pop        : discard the head word; ignored when empty
//   full/empty : occupancy flags
//   head       : word at the read pointer (valid when !empty)
// ----------------------------------------------------------------------------
module ks_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when the same cycle pops, so the
    // full test effectively looks at occupancy after the pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keystream_xor_cipher.sv
// ----------------------------------------------------------------------------
// keystream_xor_cipher
// XORs plaintext blocks with LFSR keystream words consumed strictly in index
// order. The LFSR cannot stall, so keystream is prefetched into a FIFO; when
// the FIFO is full the LFSR is reloaded and fast-forwarded to the first word
// that has not yet been captured.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, stop           : session control pulses (stop has priority)
//   in_valid/in_ready/in_data    : plaintext input handshake
//   out_valid/out_ready/out_data : ciphertext output handshake
//   ks_en                 : LFSR enable (low reloads the LFSR seed)
//   ks_word               : current LFSR output word
//   busy                  : session active (state != IDLE)
//   blk_count             : blocks produced in this session
// ----------------------------------------------------------------------------
module keystream_xor_cipher
    import ks_cipher_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WARMUP     = DEF_WARMUP,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_SIZE-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out_data,
    output logic                  ks_en,
    input  logic [BLOCK_SIZE-1:0] ks_word,
    output logic                  busy,
    output logic [CNT_W-1:0]      blk_count
);

    ks_state_t             state;
    ks_state_t             state_next;

    // ks_idx   : keystream index of the word currently on ks_word
    // push_idx : index of the next word the FIFO still needs
    logic [CNT_W-1:0]      ks_idx;
    logic [CNT_W-1:0]      push_idx;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_clear;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [BLOCK_SIZE-1:0] fifo_head;

    logic                  accept;
    logic                  can_push;
    logic                  session_start;
    logic                  session_stop;

    assign busy          = (state != IDLE);
    assign ks_en         = ks_en_for(state);
    assign in_ready      = busy & ~fifo_empty & (~out_valid | out_ready);
    assign accept        = in_valid & in_ready;
    assign fifo_pop      = accept;
    assign can_push      = ~fifo_full | fifo_pop;
    assign session_start = (state == IDLE) & start & ~stop;
    assign session_stop  = busy & stop;
    assign fifo_clear    = session_start | session_stop;

    ks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLOCK_SIZE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ks_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer. A word that finds the FIFO full is never captured; we reload
    // and walk forward again, and because push_idx did not move the walk ends
    // exactly on that missed word. If the FIFO is still full when the walk
    // arrives, the cycle simply repeats until the consumer frees a slot.
    always_comb begin
        state_next = state;
        fifo_push  = 1'b0;
        case (state)
            IDLE: begin
                if (session_start) begin
                    state_next = RELOAD;
                end
            end
            RELOAD: begin
                state_next = SKIP;
            end
            SKIP: begin
                if (ks_idx == push_idx) begin
                    if (can_push) begin
                        fifo_push  = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = RELOAD;
                    end
                end
            end
            RUN: begin
                if (can_push) begin
                    fifo_push = 1'b1;
                end else begin
                    state_next = RELOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (session_stop) begin
            state_next = IDLE;
            fifo_push  = 1'b0;
        end
    end

    // The LFSR shows index 0 the cycle after its reload edge and advances on
    // every enabled edge, so ks_idx mirrors that exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ks_idx   <= '0;
            push_idx <= '0;
        end else begin
            if (state == RELOAD) begin
                ks_idx <= '0;
            end else if (ks_en) begin
                ks_idx <= ks_idx + CNT_W'(1);
            end
            if (session_start) begin
                push_idx <= CNT_W'(WARMUP);
            end else if (fifo_push) begin
                push_idx <= push_idx + CNT_W'(1);
            end
        end
    end

    // Output register: one-cycle latency, holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            blk_count <= '0;
        end else begin
            if (session_start) begin
                blk_count <= '0;
            end else if (accept) begin
                blk_count <= blk_count + CNT_W'(1);
            end

            if (session_start || session_stop) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                out_data <= in_data ^ fifo_head;
            end
        end
    end

endmodule

// File: tb/tb_keystream_xor_cipher.sv
// ----------------------------------------------------------------------------
// tb_keystream_xor_cipher
// Encrypt instance plus a decrypt instance that can be chained behind it.
// Each instance drives its own behavioural LFSR (reload on ks_en=0, step on
// ks_en=1). Expected keystream comes from a golden word table built from
// the same polynomial and seed: ciphertext n of a session = pt ^ word[16+n].
// ----------------------------------------------------------------------------
module tb_keystream_xor_cipher;

    localparam int          WARM   = 16;
    localparam int          NWORDS = 256;
    localparam logic [31:0] SEED   = 32'hACE1_1234;
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst, start, stop, in_valid, out_ready, chain;
    logic [31:0] in_data;

    logic        enc_in_ready, enc_out_valid, enc_ks_en, enc_busy, enc_out_ready;
    logic [31:0] enc_out_data, enc_blk_count;
    logic [31:0] enc_ks_word = SEED;

    logic        dec_in_valid, dec_in_ready, dec_out_valid, dec_ks_en, dec_busy;
    logic [31:0] dec_out_data, dec_blk_count;
    logic [31:0] dec_ks_word = SEED;

    logic [31:0] words [NWORDS];
    logic [31:0] pt_q[$];
    logic [31:0] dec_q[$];
    int          out_n = 0;
    int          cyc = 0;
    int          vec_count = 0;
    int          miss_count = 0;

    assign enc_out_ready = chain ? dec_in_ready : out_ready;
    assign dec_in_valid  = chain & enc_out_valid;

    always #5 clk = ~clk;

    keystream_xor_cipher u_enc (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_ready  (enc_in_ready),
        .in_data   (in_data),
        .out_valid (enc_out_valid),
        .out_ready (enc_out_ready),
        .out_data  (enc_out_data),
        .ks_en     (enc_ks_en),
        .ks_word   (enc_ks_word),
        .busy      (enc_busy),
        .blk_count (enc_blk_count)
    );

    keystream_xor_cipher u_dec (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .in_valid  (dec_in_valid),
        .in_ready  (dec_in_ready),
        .in_data   (enc_out_data),
        .out_valid (dec_out_valid),
        .out_ready (1'b1),
        .out_data  (dec_out_data),
        .ks_en     (dec_ks_en),
        .ks_word   (dec_ks_word),
        .busy      (dec_busy),
        .blk_count (dec_blk_count)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Stand-ins for param_lfsr: enable low reloads the seed.
    always @(posedge clk) begin
        enc_ks_word <= enc_ks_en ? lfsr_step(enc_ks_word) : SEED;
        dec_ks_word <= dec_ks_en ? lfsr_step(dec_ks_word) : SEED;
        cyc         <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!enc_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!enc_in_ready) checkOutput("in_ready_timeout", 32'(enc_in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // Scoreboard: ciphertext checked against the golden table in session
    // order; decrypted blocks checked against the original plaintext.
    always @(negedge clk) begin
        logic [31:0] pt;
        if (!enc_busy) begin
            pt_q.delete();
            out_n = 0;
        end
        if (!dec_busy) dec_q.delete();
        if (enc_out_valid && enc_out_ready) begin
            if (pt_q.size() == 0 || WARM + out_n >= NWORDS) begin
                checkOutput("enc_unexpected_block", enc_out_data, 32'd0);
            end else begin
                pt = pt_q.pop_front();
                checkOutput("enc_ct", enc_out_data, pt ^ words[WARM + out_n]);
                out_n++;
            end
        end
        if (dec_out_valid) begin
            if (dec_q.size() == 0) begin
                checkOutput("dec_unexpected_block", dec_out_data, 32'd0);
            end else begin
                pt = dec_q.pop_front();
                checkOutput("dec_pt", dec_out_data, pt);
            end
        end
        if (in_valid && enc_in_ready) begin
            pt_q.push_back(in_data);
            if (chain) dec_q.push_back(in_data);
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int reload_seen;
        int t;

        words[0] = SEED;
        for (int k = 1; k < NWORDS; k++) words[k] = lfsr_step(words[k-1]);

        rst = 1'b1; start = 1'b0; stop = 1'b0; chain = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(enc_out_valid), 32'd0);
        checkOutput("rst_out_data",  enc_out_data,         32'd0);
        checkOutput("rst_blk_count", enc_blk_count,        32'd0);
        checkOutput("rst_ks_en",     32'(enc_ks_en),       32'd0);
        checkOutput("rst_busy",      32'(enc_busy),        32'd0);
        checkOutput("rst_in_ready",  32'(enc_in_ready),    32'd0);
        rst = 1'b0;

        // 1: zero plaintext exposes raw keystream, 1 block/cycle after fill
        out_ready = 1'b1;
        pulseStart();
        applyStimulus(32'd0);
        t0 = cyc;
        checkOutput("s1_first_ct", enc_out_data, words[16]);
        for (int i = 1; i < 64; i++) applyStimulus(32'd0);
        checkOutput("s1_burst_cycles", 32'(cyc - t0), 32'd63);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s1_blk_count", enc_blk_count,        32'd64);
        checkOutput("s1_drained",   32'(enc_out_valid),   32'd0);
        pulseStop();

        // 2: downstream stall fills FIFO, forces reload/skip, no index slip
        pulseStart();
        for (int i = 0; i < 3; i++) applyStimulus(32'h1111_1111 * 32'(i + 1));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reload_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (enc_busy && !enc_ks_en) reload_seen++;
        end
        checkOutput("s2_reload_seen", 32'(reload_seen != 0), 32'd1);
        checkOutput("s2_hold_valid",  32'(enc_out_valid),    32'd1);
        checkOutput("s2_hold_data",   enc_out_data,          32'h3333_3333 ^ words[18]);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(32'hA5A5_0000 + 32'(i));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s2_blk_count", enc_blk_count, 32'd13);
        checkOutput("s2_out_count", 32'(out_n),    32'd13);
        pulseStop();

        // 3: sparse traffic through encrypt -> decrypt chain
        chain = 1'b1;
        pulseStart();
        for (int i = 0; i < 200; i++) begin
            applyStimulus(32'(i) * 32'h9E37_79B9);
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("s3_enc_blk_count", enc_blk_count,         32'd200);
        checkOutput("s3_dec_blk_count", dec_blk_count,         32'd200);
        checkOutput("s3_dec_pending",   32'(dec_q.size()),     32'd0);
        pulseStop();
        chain = 1'b0;

        // 4: stop mid-burst, then restart from word 16
        pulseStart();
        for (int i = 0; i < 5; i++) applyStimulus(32'hC0DE_0000 + 32'(i));
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        in_valid = 1'b0;
        checkOutput("s4_out_valid", 32'(enc_out_valid), 32'd0);
        checkOutput("s4_busy",      32'(enc_busy),      32'd0);
        pulseStart();
        checkOutput("s4_blk_restart", enc_blk_count, 32'd0);
        applyStimulus(32'h1234_5678);
        in_valid = 1'b0;
        checkOutput("s4_first_ct", enc_out_data,  32'h1234_5678 ^ words[16]);
        checkOutput("s4_blk_one",  enc_blk_count, 32'd1);
        pulseStop();

        // 5: reset during SKIP
        pulseStart();
        applyStimulus(32'hDEAD_BEEF);
        applyStimulus(32'hFEED_F00D);
        in_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(enc_busy && !enc_ks_en) && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput("s5_reload_reached", 32'(enc_busy && !enc_ks_en), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s5_out_valid", 32'(enc_out_valid), 32'd0);
        checkOutput("s5_out_data",  enc_out_data,       32'd0);
        checkOutput("s5_blk_count", enc_blk_count,      32'd0);
        checkOutput("s5_ks_en",     32'(enc_ks_en),     32'd0);
        checkOutput("s5_busy",      32'(enc_busy),      32'd0);
        checkOutput("s5_in_ready",  32'(enc_in_ready),  32'd0);
        rst = 1'b0;
        pulseStart();
        applyStimulus(32'd0);
        checkOutput("s5_first_ct", enc_out_data, words[16]);
        for (int i = 1; i < 8; i++) applyStimulus(32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s5_blk_count_after", enc_blk_count, 32'd8);
        pulseStop();

        // 6: start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("s6_busy",     32'(enc_busy),     32'd0);
        checkOutput("s6_ks_en",    32'(enc_ks_en),    32'd0);
        checkOutput("s6_in_ready", 32'(enc_in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s6_still_idle", 32'(enc_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
